regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side controller for the 1W2R integer register file.
- Merges single-cycle ALU results and long-latency load/response results onto the single write port (we/wa/wd), buffering load results in a small FIFO.
- Keeps a 32-entry busy scoreboard of destinations with outstanding loads, which decode queries with its two read addresses.
- Sits between the execute/memory-response stages and the register file write port.

Parameters:
- LD_DEPTH, 2, load-result FIFO depth in entries (power of 2, >=2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before it is forced to win
- DWIDTH, 32, data width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle; combinational
- alu_wa  in  5  ALU destination
- alu_wd  in  DWIDTH  ALU result
- ld_valid  in  1  load result present
- ld_ready  out  1  FIFO can accept; equals !full, 0 while rst
- ld_wa  in  5  load destination
- ld_wd  in  DWIDTH  load data
- issue_valid  in  1  load issued; mark destination busy
- issue_wa  in  5  issued load destination
- ra1, ra2  in  5 each  decode read addresses
- busy1, busy2  out  1 each  combinational: busy[ra1], busy[ra2]
- we  out  1  register file write enable; registered
- wa  out  5  register file write address; registered
- wd  out  DWIDTH  register file write data; registered
- waw_err  out  1  sticky: ALU wrote a busy register

Behaviour:
- Reset (rst=1 at posedge): we=0, wa=0, wd=0; FIFO empty; all busy bits 0; starve counter 0; waw_err=0. A reset mid-operation discards FIFO contents and the scoreboard.
- FIFO push: ld_valid & ld_ready. ld_ready depends only on registered occupancy, never on a same-cycle pop. No push-to-pop bypass: an entry is written out no earlier than 2 cycles after acceptance.
- Arbitration each cycle: force = FIFO non-empty & starve_cnt==STARVE_MAX. alu_ready = !force.
- Winner is the ALU if alu_valid & !force. Otherwise the FIFO head if non-empty. Otherwise none.
- Output register on next posedge:
  - ALU wins: we=|alu_wa, wa=alu_wa, wd=alu_wd.
  - FIFO wins: pop; we=|head.wa; wa/wd from head.
  - No winner: we=0; wa/wd hold their values.
- Latency is 1 cycle from win to we. Writes to x0 are never asserted on we, although the entry is still consumed.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when the FIFO is non-empty and the ALU wins.
  - Clears when the FIFO wins or the FIFO is empty.
- Scoreboard:
  - issue_valid & issue_wa!=0 sets busy[issue_wa].
  - A FIFO pop with head.wa!=0 clears busy[head.wa] at the same posedge as it loads we.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - busy[0] is hard 0.
  - busy1/busy2 reflect the registered bits and do not see same-cycle issue or pop.
- waw_err sets when the ALU wins with alu_wa!=0 and busy[alu_wa]=1. It clears only on rst.
- Full FIFO with a simultaneous pop: ld_ready=0 that cycle and rises the cycle after.

Decomposition:
- Shared package holds: REG_AWIDTH=5, NUM_REGS=32, and the write-request struct {wa[4:0], wd[DWIDTH-1:0]}.
- One natural sub-module: wb_fifo, a synchronous single-clock FIFO with push/pop, full/empty and a registered occupancy count.
- Scoreboard and arbiter stay inline.

Test Plan:
- Reset, then ALU writes x5=0x1234 with the FIFO empty -> the next cycle has we=1, wa=5, wd=0x1234; alu_ready=1 throughout.
- Issue load to x7 -> busy1=1 when ra1=7 on the following cycle. Push ld {7, 0xDEAD} with no ALU traffic -> two cycles later we=1, wa=7, wd=0xDEAD, and busy cleared on that same edge.
- Push 2 loads and hold alu_valid=1 continuously:
  - ld_ready=0 once full.
  - After 4 ALU wins: alu_ready=0 for one cycle and the FIFO head is written.
  - starve_cnt restarts, and the second load is forced 4 ALU wins later.
- ALU writes x0 = 0xFFFF_FFFF and ld writes x0 -> we stays 0 both cycles; the FIFO still drains; busy unchanged.
- issue x9, then ALU writes x9 before the load returns -> waw_err=1 and stays 1 until rst.
- Same cycle: issue x3 and pop a load to x3 -> busy[3]=1 afterward. Then assert rst with the FIFO full -> FIFO empty, busy all 0, we=0, ld_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_writeback_pkg;

  localparam int REG_AWIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DWIDTH  = 32;

  typedef logic [REG_AWIDTH-1:0] reg_addr_t;

  // One pending register-file write: destination and data.
  typedef struct packed {
    reg_addr_t            wa;
    logic [WB_DWIDTH-1:0] wd;
  } wr_req_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Single-clock FIFO holding returned load results until they win the write port.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointer and occupancy values; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; written entries are only ever read after the count says they are valid.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; stale contents are unreachable once the pointers clear.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-port controller: arbitrates ALU results and buffered load results onto
// the register file's single write port and tracks destinations of outstanding loads.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int LD_DEPTH   = 2,
  parameter int STARVE_MAX = 4,
  parameter int DWIDTH     = WB_DWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_AWIDTH-1:0] alu_wa,
  input  logic [DWIDTH-1:0]     alu_wd,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_AWIDTH-1:0] ld_wa,
  input  logic [DWIDTH-1:0]     ld_wd,
  input  logic                  issue_valid,
  input  logic [REG_AWIDTH-1:0] issue_wa,
  input  logic [REG_AWIDTH-1:0] ra1,
  input  logic [REG_AWIDTH-1:0] ra2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  we,
  output logic [REG_AWIDTH-1:0] wa,
  output logic [DWIDTH-1:0]     wd,
  output logic                  waw_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    reg_addr_t         wa;
    logic [DWIDTH-1:0] wd;
  } ld_req_t;

  ld_req_t             fifo_in, fifo_head;
  logic                fifo_full, fifo_empty;
  logic                force_fifo, alu_win, fifo_win;
  logic [SW-1:0]       starve_q, starve_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                we_q, we_d;
  reg_addr_t           wa_q, wa_d;
  logic [DWIDTH-1:0]   wd_q, wd_d;
  logic                waw_q, waw_d;

  // ld_ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign ld_ready = !fifo_full && !rst;
  assign fifo_in  = '{wa: ld_wa, wd: ld_wd};

  wb_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH ($bits(ld_req_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ld_valid && ld_ready),
    .data_i  (fifo_in),
    .pop_i   (fifo_win),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign alu_ready = !force_fifo;
  assign busy1     = busy_q[ra1];
  assign busy2     = busy_q[ra2];
  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign waw_err   = waw_q;

  // Arbitration, output next-state, starvation counter, scoreboard and WAW detection.
  always_comb begin
    force_fifo = !fifo_empty && (starve_q == SW'(STARVE_MAX));
    alu_win    = alu_valid && !force_fifo;
    fifo_win   = !alu_win && !fifo_empty;

    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    waw_d    = waw_q;
    busy_d   = busy_q;
    starve_d = '0;

    if (alu_win) begin
      we_d = (alu_wa != '0);
      wa_d = alu_wa;
      wd_d = alu_wd;
      if ((alu_wa != '0) && busy_q[alu_wa]) waw_d = 1'b1;
    end else if (fifo_win) begin
      we_d = (fifo_head.wa != '0);
      wa_d = fifo_head.wa;
      wd_d = fifo_head.wd;
      busy_d[fifo_head.wa] = 1'b0;
    end

    // The ALU overtaking a waiting load ages the load; anything else resets the age.
    if (!fifo_empty && alu_win && (starve_q != SW'(STARVE_MAX)))
      starve_d = starve_q + 1'b1;
    else if (!fifo_empty && alu_win)
      starve_d = starve_q;

    // A new issue to the same register outranks the clear from a retiring load.
    if (issue_valid) busy_d[issue_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Write-port, scoreboard and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      waw_q    <= 1'b0;
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      waw_q    <= waw_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;

  localparam int LD_DEPTH   = 2;
  localparam int STARVE_MAX = 4;
  localparam int DWIDTH     = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_ready;
  logic [4:0]        alu_wa;
  logic [DWIDTH-1:0] alu_wd;
  logic              ld_valid, ld_ready;
  logic [4:0]        ld_wa;
  logic [DWIDTH-1:0] ld_wd;
  logic              issue_valid;
  logic [4:0]        issue_wa;
  logic [4:0]        ra1, ra2;
  logic              busy1, busy2;
  logic              we;
  logic [4:0]        wa;
  logic [DWIDTH-1:0] wd;
  logic              waw_err;

  regfile_writeback #(
    .LD_DEPTH   (LD_DEPTH),
    .STARVE_MAX (STARVE_MAX),
    .DWIDTH     (DWIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_wa      (alu_wa),
    .alu_wd      (alu_wd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_wa       (ld_wa),
    .ld_wd       (ld_wd),
    .issue_valid (issue_valid),
    .issue_wa    (issue_wa),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .waw_err     (waw_err)
  );

  always #5 clk = ~clk;

  // Reference model state: pending loads in arrival order, busy set, starvation age, write port.
  typedef struct {
    logic [4:0]        wa;
    logic [DWIDTH-1:0] wd;
  } ent_t;

  ent_t              mq[$];
  logic [31:0]       m_busy;
  int                m_starve;
  logic              m_we, m_waw;
  logic [4:0]        m_wa;
  logic [DWIDTH-1:0] m_wd;

  int   n_checks = 0;
  int   n_errors = 0;
  logic last_alu_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy   = '0;
    m_starve = 0;
    m_we     = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
    m_waw    = 1'b0;
  endtask

  // Apply one clock of the specified behaviour to the model using the currently driven inputs.
  task automatic model_advance();
    int   pre_size;
    logic room, frc, a_win, f_win;
    ent_t h;
    if (rst) begin
      model_reset();
      return;
    end
    pre_size = mq.size();
    room     = (pre_size < LD_DEPTH);
    frc      = (pre_size > 0) && (m_starve == STARVE_MAX);
    a_win    = alu_valid && !frc;
    f_win    = !a_win && (pre_size > 0);
    if (a_win) begin
      if (alu_wa != 0 && m_busy[alu_wa]) m_waw = 1'b1;
      m_we = (alu_wa != 0);
      m_wa = alu_wa;
      m_wd = alu_wd;
    end else if (f_win) begin
      h    = mq.pop_front();
      m_we = (h.wa != 0);
      m_wa = h.wa;
      m_wd = h.wd;
      if (h.wa != 0) m_busy[h.wa] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (pre_size > 0 && a_win) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else                       m_starve = 0;
    if (issue_valid && issue_wa != 0) m_busy[issue_wa] = 1'b1;
    if (ld_valid && room) mq.push_back('{wa: ld_wa, wd: ld_wd});
  endtask

  // One cycle: check combinational outputs mid-cycle, advance model, check registered outputs after the edge.
  task automatic step();
    logic frc;
    #2;
    frc = (mq.size() > 0) && (m_starve == STARVE_MAX);
    last_alu_ready = alu_ready;
    check("alu_ready", alu_ready, !frc);
    check("ld_ready", ld_ready, !rst && (mq.size() < LD_DEPTH));
    check("busy1", busy1, m_busy[ra1]);
    check("busy2", busy2, m_busy[ra2]);
    model_advance();
    @(posedge clk);
    #1;
    check("we", we, m_we);
    check("wa", wa, m_wa);
    check("wd", wd, m_wd);
    check("waw_err", waw_err, m_waw);
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_wa      = '0;
    alu_wd      = '0;
    ld_valid    = 1'b0;
    ld_wa       = '0;
    ld_wd       = '0;
    issue_valid = 1'b0;
    issue_wa    = '0;
  endtask

  initial begin
    int forced;
    rst = 1'b1;
    ra1 = '0;
    ra2 = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_we", we, 0);
    check("rst_wa", wa, 0);
    check("rst_wd", wd, 0);
    check("rst_waw", waw_err, 0);
    check("rst_ld_ready", ld_ready, 0);
    rst = 1'b0;

    // ALU write with empty FIFO appears one cycle later.
    alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'h1234;
    step();
    check("alu_first_we", we, 1);
    check("alu_first_wa", wa, 5);
    check("alu_first_wd", wd, 32'h1234);
    idle();

    // Issue load to x7, observe busy, return it, see writeback and clear.
    issue_valid = 1'b1; issue_wa = 5'd7;
    step();
    idle();
    ra1 = 5'd7;
    #1;
    check("busy_x7_set", busy1, 1);
    ld_valid = 1'b1; ld_wa = 5'd7; ld_wd = 32'hDEAD;
    step();
    check("ld_no_bypass_we", we, 0);
    idle();
    step();
    check("ld_x7_we", we, 1);
    check("ld_x7_wa", wa, 7);
    check("ld_x7_wd", wd, 32'hDEAD);
    check("busy_x7_clear", busy1, 0);

    // Two loads against continuous ALU traffic: each is forced out after STARVE_MAX ALU wins.
    forced = 0;
    for (int i = 0; i < 14; i++) begin
      alu_valid = 1'b1; alu_wa = 5'd11; alu_wd = $urandom;
      ld_valid  = (i < 2); ld_wa = (i == 0) ? 5'd10 : 5'd12; ld_wd = $urandom;
      step();
      if (!last_alu_ready) forced++;
    end
    check("forced_wins", forced, 2);
    idle();

    // Writes to x0 from both sources never raise we.
    alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'hFFFF_FFFF;
    ld_valid  = 1'b1; ld_wa = 5'd0; ld_wd = 32'h5555_AAAA;
    step();
    idle();
    step();
    step();

    // WAW: ALU overwrites a register with an outstanding load.
    issue_valid = 1'b1; issue_wa = 5'd9;
    step();
    idle();
    alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h99;
    step();
    check("waw_set", waw_err, 1);
    idle();
    repeat (3) step();
    check("waw_sticky", waw_err, 1);

    // Issue and pop to the same register in one cycle: set wins.
    ld_valid = 1'b1; ld_wa = 5'd3; ld_wd = 32'h33;
    step();
    idle();
    issue_valid = 1'b1; issue_wa = 5'd3;
    step();
    idle();
    ra1 = 5'd3;
    #1;
    check("busy_set_wins", busy1, 1);

    // Fill the FIFO, then reset mid-operation.
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = $urandom;
      ld_valid  = 1'b1; ld_wa = 5'd4; ld_wd = $urandom;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_ld_ready", ld_ready, 1);
    check("post_rst_busy", busy1, 0);
    check("post_rst_we", we, 0);
    step();

    // Randomized traffic with narrow address range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 149) == 0);
      alu_valid   = $urandom_range(0, 1);
      alu_wa      = 5'($urandom_range(0, 7));
      alu_wd      = $urandom;
      ld_valid    = $urandom_range(0, 1);
      ld_wa       = 5'($urandom_range(0, 7));
      ld_wd       = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_wa    = 5'($urandom_range(0, 7));
      ra1         = 5'($urandom_range(0, 7));
      ra2         = 5'($urandom_range(0, 31));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
